mdivp2: RTL and testbench

MDIVP2 -- requirements
Module: mdivp2

---
 rtl/mdivp2_pkg.sv | 30 +++
 rtl/mdivp2_step.sv | 31 +++
 rtl/mdivp2.sv | 132 +++++++++++++
 tb/tb_mdivp2.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdivp2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdivp2_pkg
// Brief    : Shared defaults and FSM state encoding for the modular halving
//            engine (z = x * 2^-k mod m).
// Revision : 1.0 - initial release
// ============================================================================
package mdivp2_pkg;

  // Default operand / modulus width and shift-count width
  localparam int W_DEF  = 256;
  localparam int KW_DEF = 9;

  // Controller states, explicitly encoded on two bits
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of RUN cycles needed for a given halving count
  function automatic int run_cycles(input int k, input bit radix4);
    if (radix4) begin
      return (k + 1) / 2;
    end
    return k;
  endfunction

endpackage : mdivp2_pkg
`default_nettype wire

// File: rtl/mdivp2_step.sv
`default_nettype none
// ============================================================================
// Module   : mdivp2_step
// Brief    : One combinational modular halving step.
//            even acc -> acc >> 1, odd acc -> (acc + m) >> 1.
//            The sum is formed one bit wider so the carry survives the shift;
//            for odd m and acc < m the result is always < m.
// Revision : 1.0 - initial release
// ============================================================================
module mdivp2_step #(
  parameter int W = 256
) (
  input  logic [W-1:0] acc,
  input  logic [W-1:0] m,
  output logic [W-1:0] acc_next
);

  logic [W:0] sum;
  logic       unused_lsb;

  // Add the modulus only when acc is odd, making the sum even before the shift
  always_comb begin
    sum = {1'b0, acc} + (acc[0] ? {1'b0, m} : {(W+1){1'b0}});
  end

  // The LSB of the sum is always discarded by the halving
  assign unused_lsb = sum[0];
  assign acc_next   = sum[W:1];

endmodule : mdivp2_step
`default_nettype wire

// File: rtl/mdivp2.sv
`default_nettype none
// ============================================================================
// Module   : mdivp2
// Brief    : Iterative modular halving engine, z = x * 2^-k mod m.
//            Valid/ready on both sides, one operation in flight at a time.
//            Build option MDIVP2_RADIX4_EN: two chained halvings per RUN
//            cycle (one when a single halving remains), same results.
// Revision : 1.0 - initial release
// ============================================================================
module mdivp2
  import mdivp2_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int KW = KW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  m,
  input  logic [W-1:0]  x,
  input  logic [KW-1:0] k,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  z
);

  state_t        state;
  logic [W-1:0]  acc;
  logic [W-1:0]  m_q;
  logic [KW-1:0] cnt;

  logic [W-1:0]  half1;
  logic [W-1:0]  acc_next;
  logic [KW-1:0] cnt_next;
  logic          last_step;

  // First halving stage, always present
  mdivp2_step #(.W(W)) u_step0 (
    .acc      (acc),
    .m        (m_q),
    .acc_next (half1)
  );

`ifdef MDIVP2_RADIX4_EN
  logic [W-1:0] half2;

  // Second chained stage; used whenever at least two halvings remain
  mdivp2_step #(.W(W)) u_step1 (
    .acc      (half1),
    .m        (m_q),
    .acc_next (half2)
  );

  // Pick one or two halvings depending on the remaining count
  always_comb begin
    acc_next  = half1;
    cnt_next  = cnt - KW'(1);
    last_step = (cnt == KW'(1));
    if (cnt >= KW'(2)) begin
      acc_next  = half2;
      cnt_next  = cnt - KW'(2);
      last_step = (cnt == KW'(2));
    end
  end
`else
  // One halving per cycle
  always_comb begin
    acc_next  = half1;
    cnt_next  = cnt - KW'(1);
    last_step = (cnt == KW'(1));
  end
`endif

  // Controller: accept, iterate, hold result until the consumer takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      m_q       <= '0;
      cnt       <= '0;
      z         <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            acc      <= x;
            m_q      <= m;
            cnt      <= k;
            in_ready <= 1'b0;
            if (k == '0) begin
              // Nothing to halve: the operand is the result
              state     <= DONE;
              z         <= x;
              out_valid <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end

        RUN: begin
          acc <= acc_next;
          cnt <= cnt_next;
          if (last_step) begin
            state     <= DONE;
            z         <= acc_next;
            out_valid <= 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule : mdivp2
`default_nettype wire

// File: tb/tb_mdivp2.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdivp2
// Brief    : Self-checking bench for mdivp2. A transaction-level model (modular
//            inverse of 2 raised to k, plus latency counting) predicts
//            out_valid / in_ready / z every cycle; directed cases pin values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdivp2;
  localparam int W  = 256;
  localparam int KW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  m;
  logic [W-1:0]  x;
  logic [KW-1:0] k;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  z;

  int n_cmp = 0;
  int n_bad = 0;

  mdivp2 #(.W(W), .KW(KW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .m         (m),
    .x         (x),
    .k         (k),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // x * (2^-1)^k mod m, using (m+1)/2 as the inverse of 2 for odd m
  function automatic logic [W-1:0] ref_div(input logic [W-1:0] mm, input logic [W-1:0] xx, input int kk);
    logic [2*W-1:0] mw, inv, a;
    mw  = {{W{1'b0}}, mm};
    inv = (mw + 1) >> 1;
    a   = {{W{1'b0}}, xx};
    for (int i = 0; i < kk; i++) a = (a * inv) % mw;
    return a[W-1:0];
  endfunction

  // z * 2^k mod m by repeated doubling
  function automatic logic [W-1:0] dbl_k(input logic [W-1:0] zz, input logic [W-1:0] mm, input int kk);
    logic [W:0] a, mw;
    a  = {1'b0, zz};
    mw = {1'b0, mm};
    for (int i = 0; i < kk; i++) a = (a << 1) % mw;
    return a[W-1:0];
  endfunction

  function automatic int lat_of(input int kk);
`ifdef MDIVP2_RADIX4_EN
    return (kk + 1) / 2;
`else
    return kk;
`endif
  endfunction

  function automatic logic [W-1:0] rnd_w();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W / 32; i++) r = {r[W-33:0], 32'($urandom)};
    return r;
  endfunction

  // Transaction-level model state
  logic         mv, mr, mbusy;
  logic [W-1:0] mz, mres;
  int           mleft;
  bit           chk_en = 1'b0;
  bit           z_dc   = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mv <= 1'b0; mr <= 1'b1; mbusy <= 1'b0; mz <= '0; mleft <= 0;
    end else if (mv) begin
      if (out_ready) begin mv <= 1'b0; mr <= 1'b1; mbusy <= 1'b0; end
    end else if (mbusy) begin
      if (mleft == 1) begin mv <= 1'b1; mz <= mres; end
      mleft <= mleft - 1;
    end else if (in_valid && mr) begin
      mbusy <= 1'b1;
      mr    <= 1'b0;
      mleft <= lat_of(int'(k));
      mres  <= ref_div(m, x, int'(k));
      if (k == '0) begin mv <= 1'b1; mz <= x; end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_out_valid", out_valid, mv);
      chk("cyc_in_ready", in_ready, mr);
      if (mv && !z_dc) chk("cyc_z", z, mz);
    end
  end

  task automatic do_op(input logic [W-1:0] mm, input logic [W-1:0] xx, input int kk,
                       input int hold, input bit noise,
                       output logic [W-1:0] zg, output int lat);
    int t;
    t = 0;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    chk("in_ready_wait", in_ready, 1'b1);
    m = mm; x = xx; k = KW'(kk); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 400) begin
      if (noise) begin
        in_valid  = 1'($urandom_range(0, 1));
        m         = rnd_w();
        x         = rnd_w();
        k         = KW'($urandom);
        out_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      lat++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("latency", lat, lat_of(kk) + 1);
    zg = z;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_z", z, zg);
      chk("hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_handshake_valid", out_valid, 1'b0);
  endtask

  logic [W-1:0] zg, mm, xx, p25519, exp_h;
  int           lat, kk;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; m = '0; x = '0; k = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_z", z, '0);
    rst = 1'b0;

    // Pin the reference model with hand-computed values
    chk("model_7_3_1", ref_div(256'd7, 256'd3, 1), 256'd5);
    chk("model_7_1_3", ref_div(256'd7, 256'd1, 3), 256'd1);
    chk("model_11_1_1", ref_div(256'd11, 256'd1, 1), 256'd6);

    // Directed cases
    do_op(256'd7, 256'd3, 1, 0, 1'b0, zg, lat);
    chk("d_7_3_1_z", zg, 256'd5);
    chk("d_7_3_1_lat", lat, lat_of(1) + 1);
    do_op(256'd7, 256'd1, 3, 0, 1'b0, zg, lat);
    chk("d_7_1_3_z", zg, 256'd1);
    do_op(256'd7, 256'd5, 0, 0, 1'b0, zg, lat);
    chk("d_7_5_0_z", zg, 256'd5);
    chk("d_7_5_0_lat", lat, 1);

    p25519 = {1'b0, {(W-1){1'b1}}} - 256'd18;
    exp_h  = (256'd1 << 254) - 256'd9;
    do_op(p25519, 256'd1, 1, 0, 1'b0, zg, lat);
    chk("d_25519_z", zg, exp_h);

    // Backpressure: three cycles of out_ready=0 in DONE
    do_op(256'd7, 256'd3, 1, 3, 1'b0, zg, lat);
    chk("bp_z", zg, 256'd5);

    // Reset at T+2 of a k=10 operation
    m = 256'd13; x = 256'd3; k = KW'(10); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_z", z, '0);
    do_op(256'd7, 256'd3, 1, 0, 1'b0, zg, lat);
    chk("after_abort_z", zg, 256'd5);

    // Unspecified operands (even m, x>=m) must still complete on time
    z_dc = 1'b1;
    do_op(256'd100, 256'd250, 5, 0, 1'b0, zg, lat);
    z_dc = 1'b0;

    // Randomised operations with input noise and random backpressure
    for (int n = 0; n < 30; n++) begin
      if (n % 3 == 0) mm = W'($urandom_range(3, 255)) | 256'd1;
      else begin
        mm = rnd_w() | 256'd1;
        if (mm == 256'd1) mm = 256'd3;
      end
      xx = rnd_w() % mm;
      kk = (n % 5 == 0) ? $urandom_range(0, 2) : $urandom_range(0, 300);
      do_op(mm, xx, kk, $urandom_range(0, 3), 1'b1, zg, lat);
      chk("rnd_z", zg, ref_div(mm, xx, kk));
      chk("rnd_dbl", dbl_k(zg, mm, kk), xx);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_mdivp2
`default_nettype wire
